// File: rtl/register_file.sv
// RV32I integer register file: 31 storage registers (x1..x31), x0 reads as zero.
// Two combinational read ports, one write port with no enable; selRd_i == 0 discards the write.

module register_file_entry #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            q <= '0;
        else if (we)
            q <= d;
    end

endmodule

module register_file (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] rd_i,
    input  logic [4:0]  selRd_i,
    input  logic [4:0]  selRs1_i,
    input  logic [4:0]  selRs2_i,
    output logic [31:0] rs1_o,
    output logic [31:0] rs2_o
);

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 1 << ADDR_WIDTH;

    // Slot 0 is a constant so the read mux needs no special case for x0.
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

    assign regs[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        register_file_entry #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_entry (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .we    (selRd_i == ADDR_WIDTH'(i)),
            .d     (rd_i),
            .q     (regs[i])
        );
    end

    assign rs1_o = regs[selRs1_i];
    assign rs2_o = regs[selRs2_i];

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array model of the
// architectural registers, plus directed reset, x0, same-cycle and boundary cases.

module tb_register_file;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] rd_i = '0;
    logic [4:0]  selRd_i = '0;
    logic [4:0]  selRs1_i = '0;
    logic [4:0]  selRs2_i = '0;
    logic [31:0] rs1_o;
    logic [31:0] rs2_o;

    logic        clk_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [32];

    register_file dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_i     (rd_i),
        .selRd_i  (selRd_i),
        .selRs1_i (selRs1_i),
        .selRs2_i (selRs2_i),
        .rs1_o    (rs1_o),
        .rs2_o    (rs2_o)
    );

    always begin
        #5;
        if (clk_en) clk_i = ~clk_i;
    end

    // Architectural model: reset wipes everything at once, otherwise each edge stores rd_i.
    initial for (int i = 0; i < 32; i++) model[i] = '0;
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            for (int i = 0; i < 32; i++) model[i] = '0;
        else if (selRd_i != 0)
            model[selRd_i] = rd_i;
    end

    function automatic logic [31:0] expect_of(input logic [4:0] sel);
        return (sel == 0) ? 32'h0 : model[sel];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            selRs1_i = 5'(i);
            selRs2_i = 5'(31 - i);
            #1;
            check({tag, "_rs1"}, rs1_o, expect_of(selRs1_i));
            check({tag, "_rs2"}, rs2_o, expect_of(selRs2_i));
        end
    endtask

    task automatic write(input logic [4:0] idx, input logic [31:0] data);
        @(negedge clk_i);
        selRd_i = idx;
        rd_i    = data;
        @(posedge clk_i);
        #1;
        selRd_i = '0;
    endtask

    initial begin
        // Reset with the clock stopped.
        #10;
        sweep("rst_noclk");
        for (int i = 0; i < 32; i++) begin
            selRs1_i = 5'(i);
            selRs2_i = 5'(i);
            #1;
            check("rst_zero_rs1", rs1_o, 32'h0);
            check("rst_zero_rs2", rs2_o, 32'h0);
        end
        rst_i  = 1'b1;
        #2;
        clk_en = 1'b1;

        // Basic write/read including the top register.
        write(5'd5, 32'hDEADBEEF);
        write(5'd31, 32'h12345678);
        selRs1_i = 5'd5;
        selRs2_i = 5'd31;
        #1;
        check("basic_x5", rs1_o, 32'hDEADBEEF);
        check("basic_x31", rs2_o, 32'h12345678);

        // x0 ignores writes.
        @(negedge clk_i);
        selRd_i = 5'd0;
        rd_i    = 32'hFFFFFFFF;
        repeat (4) @(posedge clk_i);
        #1;
        selRs1_i = 5'd0;
        selRs2_i = 5'd0;
        #1;
        check("x0_rs1", rs1_o, 32'h0);
        check("x0_rs2", rs2_o, 32'h0);
        sweep("x0_others");

        // Same-cycle read/write: old value before the edge, new after.
        write(5'd7, 32'hAAAA0000);
        @(negedge clk_i);
        selRd_i  = 5'd7;
        rd_i     = 32'h5555FFFF;
        selRs1_i = 5'd7;
        #1;
        check("rw_before", rs1_o, 32'hAAAA0000);
        @(posedge clk_i);
        #1;
        check("rw_after", rs1_o, 32'h5555FFFF);
        selRd_i = '0;

        // Both ports on one register.
        selRs1_i = 5'd5;
        selRs2_i = 5'd5;
        #1;
        check("dual_rs1", rs1_o, 32'hDEADBEEF);
        check("dual_rs2", rs2_o, 32'hDEADBEEF);

        // Randomized traffic, occasionally pulsing reset between edges.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_i);
            rst_i    = ($urandom_range(0, 39) != 0);
            selRd_i  = 5'($urandom_range(0, 31));
            rd_i     = $urandom;
            selRs1_i = ($urandom_range(0, 3) == 0) ? selRd_i : 5'($urandom_range(0, 31));
            selRs2_i = 5'($urandom_range(0, 31));
            #1;
            check("rnd_pre_rs1", rs1_o, expect_of(selRs1_i));
            check("rnd_pre_rs2", rs2_o, expect_of(selRs2_i));
            @(posedge clk_i);
            #1;
            check("rnd_post_rs1", rs1_o, expect_of(selRs1_i));
            check("rnd_post_rs2", rs2_o, expect_of(selRs2_i));
            @(negedge clk_i);
            rst_i = 1'b1;
        end

        // Async reset mid-run: contents vanish before the next edge.
        for (int i = 1; i < 32; i++) write(5'(i), 32'(i));
        sweep("filled");
        @(negedge clk_i);
        selRd_i = 5'd9;
        rd_i    = 32'hCAFEF00D;
        #1;
        rst_i = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            selRs1_i = 5'(i);
            selRs2_i = 5'(i);
            #0.1;
            check("midrst_rs1", rs1_o, 32'h0);
            check("midrst_rs2", rs2_o, 32'h0);
        end
        @(posedge clk_i);
        #1;
        selRs1_i = 5'd9;
        #1;
        check("midrst_nowrite", rs1_o, 32'h0);
        selRd_i = '0;
        @(negedge clk_i);
        rst_i = 1'b1;
        write(5'd3, 32'h3);
        selRs1_i = 5'd3;
        #1;
        check("post_rst_x3", rs1_o, 32'h3);
        for (int i = 0; i < 32; i++) begin
            selRs1_i = 5'(i);
            #1;
            check("post_rst_all", rs1_o, (i == 3) ? 32'h3 : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
